regfile_mp: RTL

Parametrised multi-port register file, the successor of the single-write-port register file in the multicycle core. It supports configurable width and depth and two write ports, with byte enables on port A. It adds optional write-to-read bypass, a per-register busy scoreboard for multicycle/out-of-order writeback, and a sequential clear engine. It sits between decode (read/reserve) and writeback (write) in the datapath.

---
 rtl/regfile_mp_if.sv | 37 +++
 rtl/regfile_mp.sv | 138 +++++++++++++
 2 files changed

// File: rtl/regfile_mp_if.sv
// Port bundle for regfile_mp: two read ports with scoreboard bits, two write ports,
// the reserve strobe and the clear-engine handshake.
interface regfile_mp_if #(
  parameter int WIDTH = 32,
  parameter int AW    = 5
);
  logic [AW-1:0]      ra1;
  logic [AW-1:0]      ra2;
  logic [WIDTH-1:0]   rd1;
  logic [WIDTH-1:0]   rd2;
  logic               busy1;
  logic               busy2;
  logic               we_a;
  logic [AW-1:0]      wa_a;
  logic [WIDTH-1:0]   wd_a;
  logic [WIDTH/8-1:0] be_a;
  logic               we_b;
  logic [AW-1:0]      wa_b;
  logic [WIDTH-1:0]   wd_b;
  logic               rsv_en;
  logic [AW-1:0]      rsv_addr;
  logic               clr_req;
  logic               clr_busy;
  logic               clr_done;

  modport master (
    output ra1, ra2, we_a, wa_a, wd_a, be_a, we_b, wa_b, wd_b,
           rsv_en, rsv_addr, clr_req,
    input  rd1, rd2, busy1, busy2, clr_busy, clr_done
  );

  modport slave (
    input  ra1, ra2, we_a, wa_a, wd_a, be_a, we_b, wa_b, wd_b,
           rsv_en, rsv_addr, clr_req,
    output rd1, rd2, busy1, busy2, clr_busy, clr_done
  );
endinterface

// File: rtl/regfile_mp.sv
// Two-write-port register file with byte enables on port A, optional write-to-read
// bypass, a per-register busy scoreboard and a one-register-per-cycle clear engine.
module regfile_mp #(
  parameter int WIDTH    = 32,
  parameter int AW       = 5,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  regfile_mp_if.slave bus
);
  localparam int NREGS = 2 ** AW;
  localparam int NB    = WIDTH / 8;

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  state_t           state_reg;
  logic [AW-1:0]    idx_reg;
  logic             clr_busy_reg;
  logic             clr_done_reg;
  logic [WIDTH-1:0] regs_reg  [NREGS];
  logic [WIDTH-1:0] regs_next [NREGS];
  logic [NREGS-1:0] busy_reg;
  logic [NREGS-1:0] busy_next;
  logic             act_a;
  logic             act_b;
  logic             act_r;

  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (ZERO_REG == 0) || (a != '0);
  endfunction

  // All writes and reserves are suppressed while the sweep owns the array.
  assign act_a = bus.we_a   && (state_reg == IDLE) && addr_ok(bus.wa_a);
  assign act_b = bus.we_b   && (state_reg == IDLE) && addr_ok(bus.wa_b);
  assign act_r = bus.rsv_en && (state_reg == IDLE) && addr_ok(bus.rsv_addr);

  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      regs_next[i] = regs_reg[i];
      if (act_a && (bus.wa_a == AW'(i))) begin
        for (int b = 0; b < NB; b++) begin
          if (bus.be_a[b]) regs_next[i][8*b +: 8] = bus.wd_a[8*b +: 8];
        end
      end
      if (act_b && (bus.wa_b == AW'(i))) regs_next[i] = bus.wd_b;
      if ((state_reg == CLEAR) && (idx_reg == AW'(i))) regs_next[i] = '0;
    end
  end

  // Reserve is applied last so it beats a same-cycle writeback.
  always_comb begin
    busy_next = busy_reg;
    if (act_a) busy_next[bus.wa_a] = 1'b0;
    if (act_b) busy_next[bus.wa_b] = 1'b0;
    if (act_r) busy_next[bus.rsv_addr] = 1'b1;
    if (state_reg == CLEAR) busy_next[idx_reg] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs_reg[i] <= '0;
      busy_reg <= '0;
    end else begin
      regs_reg <= regs_next;
      busy_reg <= busy_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      idx_reg      <= '0;
      clr_busy_reg <= 1'b0;
      clr_done_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          clr_done_reg <= 1'b0;
          if (bus.clr_req) begin
            state_reg    <= CLEAR;
            idx_reg      <= '0;
            clr_busy_reg <= 1'b1;
          end
        end
        CLEAR: begin
          idx_reg <= idx_reg + 1'b1;
          if (idx_reg == AW'(NREGS - 1)) begin
            state_reg    <= IDLE;
            clr_busy_reg <= 1'b0;
            clr_done_reg <= 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_rd
    logic [AW-1:0]    ra;
    logic [WIDTH-1:0] rd;
    logic             bz;
    logic             hit_a;
    logic             hit_b;
    logic             hit_r;

    assign ra    = (gi == 0) ? bus.ra1 : bus.ra2;
    assign hit_a = act_a && (bus.wa_a == ra);
    assign hit_b = act_b && (bus.wa_b == ra);
    assign hit_r = act_r && (bus.rsv_addr == ra);

    always_comb begin
      rd = regs_reg[ra];
      bz = busy_reg[ra];
      if (BYPASS != 0) begin
        for (int b = 0; b < NB; b++) begin
          if (hit_a && bus.be_a[b]) rd[8*b +: 8] = bus.wd_a[8*b +: 8];
        end
        if (hit_b) rd = bus.wd_b;
        if (hit_a || hit_b) bz = 1'b0;
        if (hit_r) bz = 1'b1;
      end
      if (!addr_ok(ra)) begin
        rd = '0;
        bz = 1'b0;
      end
    end
  end

  assign bus.rd1      = g_rd[0].rd;
  assign bus.rd2      = g_rd[1].rd;
  assign bus.busy1    = g_rd[0].bz;
  assign bus.busy2    = g_rd[1].bz;
  assign bus.clr_busy = clr_busy_reg;
  assign bus.clr_done = clr_done_reg;
endmodule
